dma_bus_arbiter: RTL
====================

// Module: dma_bus_arbiter
// PURPOSE
// - Sits between the TV80 core, the simpledma master and the SoC memory/IO bus.
// - Consumes simpledma's busrq_n, forwards it to TV80 BUSRQ, waits for TV80 BUSAK, then grants the bus.
// - Muxes address, data and strobes onto the shared bus, with a settle gap at every ownership change.
// - Optional watchdog forcibly reclaims the bus from a stuck DMA master.
// PARAMETERS
// - GRANT_DELAY  2    idle-bus cycles between ownership change and grant/release (1..15)
// - MAX_HOLD     255  watchdog limit in GRANTED cycles (8-bit; 0 = never expire); used only with ARB_WATCHDOG_EN
// PORTS
// - clk          in   1   system clock, all state on posedge
// - reset        in   1   asynchronous, active-high reset
// - cpu_addr     in   16  TV80 address
// - cpu_dout     in   8   TV80 write data
// - cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n   in  1 each  TV80 strobes
// - cpu_busrq_n  out  1   bus request to TV80
// - cpu_busak_n  in   1   bus acknowledge from TV80
// - dma_busrq_n  in   1   request from simpledma
// - dma_busak_n  out  1   grant to simpledma
// - dma_addr     in   16  DMA address
// - dma_dout     in   8   DMA write data
// - dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n   in  1 each  DMA strobes
// - bus_addr     out  16  shared bus address
// - bus_dout     out  8   shared bus write data
// - bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n   out 1 each  shared bus strobes
// - wd_timeout   out  1   one-cycle pulse on watchdog expiry (tied 0 without ARB_WATCHDOG_EN)
// - debug        out  8   {state[2:0], lockout, hold_cnt[3:0]}
// BEHAVIOUR
// - States: IDLE, REQ, SETTLE, GRANTED, RELEASE; encoding 3 bits, registered.
// - Reset: IDLE; cpu_busrq_n=1, dma_busak_n=1, wd_timeout=0, counters 0, lockout 0.
// - Bus mux (combinational from state): IDLE/REQ -> CPU signals; GRANTED -> DMA signals;
//   SETTLE/RELEASE -> all strobes 1, addr 16'h0, dout 8'h0.
// - IDLE: dma_busrq_n=0 and lockout=0 -> REQ, cpu_busrq_n<=0 same edge.
// - REQ: cpu_busak_n=0 -> SETTLE (delay cnt<=0); dma_busrq_n=1 first -> RELEASE (abort).
// - SETTLE: count GRANT_DELAY cycles; then GRANTED, dma_busak_n<=0. First DMA-driven cycle is
//   GRANT_DELAY+1 clocks after TV80 BUSAK sampled low.
// - GRANTED: hold_cnt increments per cycle, saturates 8'hFF. Leave to RELEASE on
//   dma_busrq_n=1, cpu_busak_n=1 (unexpected CPU release, priority over all), or watchdog.
// - RELEASE: dma_busak_n<=1 on entry; GRANT_DELAY cycles bus idle; then cpu_busrq_n<=1, IDLE.
// - Minimum one IDLE cycle between grants; a request held low across RELEASE re-enters REQ
//   on the cycle after IDLE, never directly.
// - Simultaneous dma_busrq_n rising and watchdog expiry: treated as normal release, no pulse.
// - reset mid-transfer: outputs return to reset values asynchronously; bus reverts to CPU.
// CONFIGURATION
// - ARB_WATCHDOG_EN defined: in GRANTED, hold_cnt == MAX_HOLD (MAX_HOLD != 0) -> RELEASE,
//   wd_timeout=1 for one cycle, lockout<=1; lockout clears when dma_busrq_n sampled 1.
//   DMA must withdraw its request before it can be granted again.
// - ARB_WATCHDOG_EN undefined: no expiry, wd_timeout tied 0, lockout constant 0; hold_cnt
//   still feeds debug.
// TESTING
// - Reset, CPU drives addr 16'h1234 mreq_n=0 -> bus_addr=16'h1234, cpu_busrq_n=1, dma_busak_n=1.
// - dma_busrq_n=0, TV80 busak low 3 cycles later -> dma_busak_n low exactly 3 clocks after
//   busak sample (GRANT_DELAY=2); DMA addr 16'h0201 data 8'h55 wr_n=0 appear on bus.
// - dma_busrq_n=1 while GRANTED -> dma_busak_n=1 next edge, strobes 1 for 2 cycles,
//   cpu_busrq_n=1, bus back to CPU.
// - dma_busrq_n pulses low 1 cycle then high before BUSAK -> REQ->RELEASE, dma_busak_n never 0.
// - ARB_WATCHDOG_EN, MAX_HOLD=8, request held -> wd_timeout pulse at hold 8, no re-grant until
//   dma_busrq_n high one cycle; without macro grant held 300 cycles, wd_timeout stays 0.
// - reset asserted in GRANTED -> same cycle dma_busak_n=1, cpu_busrq_n=1, bus shows CPU.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// Bus arbiter between the TV80 core and the simpledma master, with a settle gap at every ownership change.
// Build option: define ARB_WATCHDOG_EN to let a watchdog reclaim the bus from a DMA master that holds it too long.
module dma_bus_arbiter #(
    parameter int unsigned GRANT_DELAY = 2,
    parameter int unsigned MAX_HOLD    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic        cpu_busrq_n,
    input  logic        cpu_busak_n,
    input  logic        dma_busrq_n,
    output logic        dma_busak_n,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_dout,
    input  logic        dma_mreq_n,
    input  logic        dma_iorq_n,
    input  logic        dma_rd_n,
    input  logic        dma_wr_n,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_mreq_n,
    output logic        bus_iorq_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    output logic        wd_timeout,
    output logic [7:0]  debug
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HOLD_W = 8;

    localparam logic [CNT_W-1:0]  LP_SETTLE_END  = CNT_W'(GRANT_DELAY);
    localparam logic [CNT_W-1:0]  LP_RELEASE_END = CNT_W'(GRANT_DELAY - 1);
    localparam logic [HOLD_W-1:0] LP_MAX_HOLD    = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] LP_HOLD_SAT    = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GRANTED = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CNT_W-1:0]    r_dly_cnt;
    logic [CNT_W-1:0]    w_dly_cnt_nx;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nx;
    logic                r_cpu_busrq_n;
    logic                w_cpu_busrq_n_nx;
    logic                r_dma_busak_n;
    logic                w_dma_busak_n_nx;
    logic                r_wd_timeout;
    logic                w_wd_timeout_nx;
    logic                r_lockout;
    logic                w_lockout_nx;
    logic                w_wd_en;
    logic                w_hold_max;
    logic                w_expire;

`ifdef ARB_WATCHDOG_EN
    assign w_wd_en = 1'b1;
`else
    assign w_wd_en = 1'b0;
`endif

    // With the watchdog compiled out w_expire is constant 0, so lockout and wd_timeout stay 0.
    assign w_hold_max = (MAX_HOLD != 0) && (r_hold_cnt == LP_MAX_HOLD);
    assign w_expire   = w_wd_en & w_hold_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_dly_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_cpu_busrq_n <= 1'b1;
            r_dma_busak_n <= 1'b1;
            r_wd_timeout  <= 1'b0;
            r_lockout     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_dly_cnt     <= w_dly_cnt_nx;
            r_hold_cnt    <= w_hold_cnt_nx;
            r_cpu_busrq_n <= w_cpu_busrq_n_nx;
            r_dma_busak_n <= w_dma_busak_n_nx;
            r_wd_timeout  <= w_wd_timeout_nx;
            r_lockout     <= w_lockout_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_dly_cnt_nx     = r_dly_cnt;
        w_hold_cnt_nx    = r_hold_cnt;
        w_cpu_busrq_n_nx = r_cpu_busrq_n;
        w_dma_busak_n_nx = r_dma_busak_n;
        w_wd_timeout_nx  = 1'b0;
        w_lockout_nx     = dma_busrq_n ? 1'b0 : r_lockout;

        case (r_state)
            ST_IDLE: begin
                if (!dma_busrq_n && !r_lockout) begin
                    w_state_nx       = ST_REQ;
                    w_cpu_busrq_n_nx = 1'b0;
                end
            end
            ST_REQ: begin
                if (dma_busrq_n) begin
                    w_state_nx   = ST_RELEASE;
                    w_dly_cnt_nx = '0;
                end else if (!cpu_busak_n) begin
                    w_state_nx   = ST_SETTLE;
                    w_dly_cnt_nx = '0;
                end
            end
            // Stays GRANT_DELAY+1 cycles so DMA drives the bus GRANT_DELAY+1 clocks after BUSAK.
            ST_SETTLE: begin
                if (r_dly_cnt == LP_SETTLE_END) begin
                    w_state_nx       = ST_GRANTED;
                    w_dma_busak_n_nx = 1'b0;
                    w_hold_cnt_nx    = '0;
                end else begin
                    w_dly_cnt_nx = r_dly_cnt + CNT_W'(1);
                end
            end
            ST_GRANTED: begin
                if (r_hold_cnt != LP_HOLD_SAT) begin
                    w_hold_cnt_nx = r_hold_cnt + HOLD_W'(1);
                end
                if (cpu_busak_n || dma_busrq_n) begin
                    w_state_nx       = ST_RELEASE;
                    w_dma_busak_n_nx = 1'b1;
                    w_dly_cnt_nx     = '0;
                end else if (w_expire) begin
                    w_state_nx       = ST_RELEASE;
                    w_dma_busak_n_nx = 1'b1;
                    w_dly_cnt_nx     = '0;
                    w_wd_timeout_nx  = 1'b1;
                    w_lockout_nx     = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (r_dly_cnt == LP_RELEASE_END) begin
                    w_state_nx       = ST_IDLE;
                    w_cpu_busrq_n_nx = 1'b1;
                end else begin
                    w_dly_cnt_nx = r_dly_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Shared bus mux: CPU owns it outside a grant, nobody drives it during the settle gaps.
    always_comb begin
        bus_addr   = 16'h0;
        bus_dout   = 8'h0;
        bus_mreq_n = 1'b1;
        bus_iorq_n = 1'b1;
        bus_rd_n   = 1'b1;
        bus_wr_n   = 1'b1;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                bus_addr   = cpu_addr;
                bus_dout   = cpu_dout;
                bus_mreq_n = cpu_mreq_n;
                bus_iorq_n = cpu_iorq_n;
                bus_rd_n   = cpu_rd_n;
                bus_wr_n   = cpu_wr_n;
            end
            ST_GRANTED: begin
                bus_addr   = dma_addr;
                bus_dout   = dma_dout;
                bus_mreq_n = dma_mreq_n;
                bus_iorq_n = dma_iorq_n;
                bus_rd_n   = dma_rd_n;
                bus_wr_n   = dma_wr_n;
            end
            default: begin
                bus_addr = 16'h0;
            end
        endcase
    end

    assign cpu_busrq_n = r_cpu_busrq_n;
    assign dma_busak_n = r_dma_busak_n;
    assign wd_timeout  = r_wd_timeout;
    assign debug       = {r_state, r_lockout, r_hold_cnt[3:0]};

endmodule
